clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Programmable clock divider: successor of the fixed 4-ratio divider. Produces a divided
//  square wave q plus a one-cycle tick at each q rising edge, for any ratio up to 2**CNT_W-1.
//  Ratio changes via load/ack handshake and take effect only at a period boundary
//  (glitch-free). Sits between the board clock and slow peripherals (LED/scan/UART timing).
// PARAMETERS
//  CNT_W    16  width of ratio and period counter
//  DIV_RST  4   ratio loaded at reset (must be < 2**CNT_W)
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  reset     in   1      asynchronous, active-low reset
//  en        in   1      run enable; low stops the divider
//  div_i     in   CNT_W  new division ratio R
//  div_load  in   1      one-cycle strobe: capture div_i as pending ratio
//  div_ack   out  1      one-cycle pulse: pending ratio has become active
//  q         out  1      divided clock, period R cycles
//  tick      out  1      high one cycle, coincident with each q rising edge
//  active    out  1      high while FSM is in RUN
// BEHAVIOUR
//  - Reset (reset=0, async): cnt=0, ratio=DIV_RST, pend_vld=0, FSM=IDLE;
//    q=0, tick=0, div_ack=0, active=0. All outputs registered.
//  - FSM IDLE->RUN on edge where en=1 and ratio>=1; RUN->IDLE on edge where en=0
//    (q,tick forced 0 on that edge, cnt=0). ratio=0 while RUN -> IDLE at wrap.
//  - Entering RUN: cnt=0, q=1, tick=1 on the same edge (latency 1 cycle from en).
//  - RUN: cnt counts 0..R-1 and wraps; q=1 for cnt<H, H=R-(R>>1) (ceil R/2);
//    tick=1 when cnt==0. R=1: q held 1, tick every cycle. Even R: exact 50% duty.
//  - Load: div_load captures div_i into pend; pend_vld=1. A second load before
//    application overwrites pend; only the final value is acked (one ack total).
//  - Apply: in RUN, pend moves to ratio on the wrap edge (cnt==R-1) strictly after the
//    capture cycle; load on the wrap cycle itself applies at the following wrap.
//    In IDLE, pend applies on the edge after capture. div_ack pulses the cycle
//    after application; pend_vld clears then.
//  - Simultaneous div_load and application of earlier pend: earlier value applied and
//    acked, new value stays pending.
//  - Reset mid-period: outputs to reset values immediately; pending ratio discarded.
//  - Counter compare in CNT_W bits, unsigned; no overflow since cnt<=R-1<2**CNT_W.
// CONFIGURATION
//  ODD_DUTY50_EN defined: for odd R>=3 q falls half a cycle early via a falling-edge
//   flop (q = q_pos & ~fall_neg), giving exact 50% duty; tick unchanged.
//  ODD_DUTY50_EN undefined: odd R gives q high (R+1)/2 cycles, low (R-1)/2; single-edge design.
// STRUCTURE
//  - Package clk_div_pkg: state encoding (ST_IDLE=0, ST_RUN=1), default CNT_W,
//    helper constant/function for high-phase length H.
//  - Sub-module clk_div_cnt: period counter + wrap/high-phase compare; top holds FSM,
//    pending-ratio handshake and output registers.
// TESTING
//  1 reset, en=1, R=DIV_RST=4 -> q 1,1,0,0 repeating; tick every 4th cycle; active=1
//    one cycle after en.
//  2 R=5, no macro -> q high 3 / low 2 cycles; with ODD_DUTY50_EN high 2.5 / low 2.5.
//  3 running R=4, load 6 at cnt=1 -> finish 4-cycle period, then 6-cycle periods;
//    div_ack one pulse the cycle after the wrap.
//  4 two loads (8 then 3) within one period -> only 3 applied, exactly one div_ack.
//  5 load on cycle with cnt==R-1 -> applied at next wrap, not current one.
//  6 en=0 mid-period -> q=0, tick=0, active=0 next edge; reset low mid-run ->
//    outputs 0 asynchronously, ratio returns to 4.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encoding, defaults and high-phase helper for clk_div_prog
package clk_div_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int DIV_RST_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // High-phase length ceil(R/2); q stays high while cnt is below it
  function automatic logic [31:0] high_len(input logic [31:0] r);
    return r - (r >> 1);
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// clk_div_cnt: period counter with wrap and high-phase compares for clk_div_prog
// ODD_DUTY50_EN adds a flag marking the last high cycle of an odd period.
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_ratio,
  output logic             o_wrap,
  output logic             o_hi_next
`ifdef ODD_DUTY50_EN
  ,
  output logic             o_last_hi
`endif
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_h       = CNT_W'(high_len(32'(i_ratio)));
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign o_wrap    = r_cnt == i_ratio - CNT_W'(1);
  assign o_hi_next = w_cnt_inc < w_h;

`ifdef ODD_DUTY50_EN
  assign o_last_hi = i_ratio[0] && (i_ratio > CNT_W'(1)) && (r_cnt == w_h - CNT_W'(1));
`endif

  // Count 0..R-1 while running and wrap; hold at 0 whenever the divider is stopped
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else r_cnt <= (i_run && !o_wrap) ? w_cnt_inc : '0;

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock divider with glitch-free ratio load/ack handshake
// Optional ODD_DUTY50_EN: falling-edge flop trims q for exact 50% duty at odd ratios.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load,
  output logic             div_ack,
  output logic             q,
  output logic             tick,
  output logic             active
);

  state_t           r_state;
  logic [CNT_W-1:0] r_ratio;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_vld;
  logic             r_q;
  logic             r_tick;
  logic             r_ack;

  logic             w_cnt_wrap;
  logic             w_hi_next;
  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_ratio_eff;

  // A pending ratio lands immediately when idle, otherwise only on a period boundary
  assign w_wrap      = (r_state == ST_RUN) && w_cnt_wrap;
  assign w_apply     = r_pend_vld && ((r_state == ST_IDLE) || w_wrap);
  assign w_ratio_eff = w_apply ? r_pend : r_ratio;

`ifdef ODD_DUTY50_EN
  logic w_last_hi;
  logic r_fall_neg;

  clk_div_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_run     ((r_state == ST_RUN) && en),
    .i_ratio   (r_ratio),
    .o_wrap    (w_cnt_wrap),
    .o_hi_next (w_hi_next),
    .o_last_hi (w_last_hi)
  );

  // Pull q low for the second half of the last high cycle of an odd period
  always_ff @(negedge clk or negedge reset)
    if (!reset) r_fall_neg <= 1'b0;
    else r_fall_neg <= (r_state == ST_RUN) && w_last_hi;

  assign q = r_q & ~r_fall_neg;
`else
  clk_div_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_run     ((r_state == ST_RUN) && en),
    .i_ratio   (r_ratio),
    .o_wrap    (w_cnt_wrap),
    .o_hi_next (w_hi_next)
  );

  assign q = r_q;
`endif

  // FSM, ratio handshake and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ratio    <= CNT_W'(DIV_RST);
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_q        <= 1'b0;
      r_tick     <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_ack <= w_apply;
      if (w_apply) r_ratio <= r_pend;
      if (div_load) begin
        r_pend     <= div_i;
        r_pend_vld <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end
      if (r_state == ST_IDLE) begin
        if (en && (w_ratio_eff != '0)) begin
          r_state <= ST_RUN;
          r_q     <= 1'b1;
          r_tick  <= 1'b1;
        end else begin
          r_q    <= 1'b0;
          r_tick <= 1'b0;
        end
      end else if (!en || (w_wrap && (w_ratio_eff == '0))) begin
        r_state <= ST_IDLE;
        r_q     <= 1'b0;
        r_tick  <= 1'b0;
      end else begin
        r_q    <= w_wrap ? 1'b1 : w_hi_next;
        r_tick <= w_wrap;
      end
    end
  end

  assign div_ack = r_ack;
  assign tick    = r_tick;
  assign active  = (r_state == ST_RUN);

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed and randomized checks of clk_div_prog against a period-level model
module tb_clk_div_prog;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] div_i = '0;
  logic         div_load = 1'b0;
  logic         div_ack;
  logic         q;
  logic         tick;
  logic         active;

  int checks = 0;
  int errors = 0;
  int acks = 0;
  int acks0;

  bit m_run, m_pv, m_ack;
  int m_phase, m_r, m_pend;

  clk_div_prog #(.CNT_W(W), .DIV_RST(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_i    (div_i),
    .div_load (div_load),
    .div_ack  (div_ack),
    .q        (q),
    .tick     (tick),
    .active   (active)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pv = 0; m_ack = 0; m_phase = 0; m_r = 4; m_pend = 0;
  endtask

  // One clock: the model advances by the divider's period rules, then outputs are compared
  task automatic step(bit e, bit ld, int d);
    bit wrap, apply;
    int new_r;
    en = e; div_load = ld; div_i = W'(d);
    wrap  = m_run && (m_phase == m_r - 1);
    apply = m_pv && (!m_run || wrap);
    new_r = apply ? m_pend : m_r;
    m_ack = apply;
    if (!m_run) begin
      if (e && new_r >= 1) begin m_run = 1; m_phase = 0; end
    end else if (!e) m_run = 0;
    else if (wrap) begin
      if (new_r == 0) m_run = 0; else m_phase = 0;
    end else m_phase++;
    m_r = new_r;
    if (ld) begin m_pend = d; m_pv = 1; end
    else if (apply) m_pv = 0;
    @(posedge clk); #1;
    if (div_ack) acks++;
    check("q", q, m_run && (m_phase < (m_r + 1) / 2));
    check("tick", tick, m_run && m_phase == 0);
    check("active", active, m_run);
    check("ack", div_ack, m_ack);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_q", q, 0);
    check("rst_tick", tick, 0);
    check("rst_active", active, 0);
    check("rst_ack", div_ack, 0);
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_q", q, 0);
    check("reset_tick", tick, 0);
    check("reset_active", active, 0);
    check("reset_ack", div_ack, 0);
    #11 reset = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    check("idle_active", active, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      check("t1_q", q, (i % 4) < 2);
      check("t1_tick", tick, (i % 4) == 0);
      check("t1_active", active, 1);
    end
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 6);
    step(1, 0, 0);
    check("t3_no_ack_yet", div_ack, 0);
    step(1, 0, 0);
    check("t3_ack", div_ack, 1);
    check("t3_tick", tick, 1);
    for (int i = 1; i < 6; i++) begin
      step(1, 0, 0);
      check("t3_q6", q, i < 3);
      check("t3_ack_once", div_ack, 0);
    end
    step(1, 0, 0);
    check("t3_wrap6", tick, 1);
    for (int k = 0; k < 12 && m_phase != 0; k++) step(1, 0, 0);
    acks0 = acks;
    step(1, 1, 8);
    step(1, 0, 0);
    step(1, 1, 3);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    check("t4_one_ack", acks - acks0, 1);
    for (int k = 0; k < 12 && m_phase != 2; k++) step(1, 0, 0);
    step(1, 1, 5);
    check("t5_wrap_tick", tick, 1);
    check("t5_no_ack0", div_ack, 0);
    step(1, 0, 0);
    check("t5_no_ack1", div_ack, 0);
    step(1, 0, 0);
    check("t5_no_ack2", div_ack, 0);
    step(1, 0, 0);
    check("t5_ack", div_ack, 1);
    check("t5_q0", q, 1);
    for (int i = 1; i < 5; i++) begin
      step(1, 0, 0);
      check("t2_q5", q, i < 3);
    end
    step(1, 0, 0);
    check("t2_wrap5", tick, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    check("t6_q", q, 0);
    check("t6_tick", tick, 0);
    check("t6_active", active, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      check("t6_ratio4", q, (i % 4) < 2);
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      step($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 9)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
